// File: rtl/dotp_pkg.sv
// Shared definitions for the dot-product controller slice.
// Holds the controller state type and the default parameter constants
// used by dotp_controller and dotp_mac.
package dotp_pkg;

  localparam int DOTP_ADDR_WIDTH   = 12;
  localparam int DOTP_DATA_WIDTH   = 32;
  localparam int DOTP_LEN_WIDTH    = 8;
  localparam int DOTP_RESULT_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ_A,
    WAIT_A,
    REQ_B,
    WAIT_B,
    DONE
  } dotp_state_e;

endpackage

// File: rtl/dotp_mac.sv
// Signed multiply-accumulate unit for the dot-product controller.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the accumulator (takes priority over en)
//   en       : add a*b (signed, full 2*DATA_W product) into the accumulator
//   a, b     : two's-complement operands
//   acc      : running sum, wraps modulo 2^ACC_W
module dotp_mac
  import dotp_pkg::*;
#(
  parameter int DATA_W = DOTP_DATA_WIDTH,
  parameter int ACC_W  = DOTP_RESULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic signed [DATA_W-1:0]   a_s;
  logic signed [DATA_W-1:0]   b_s;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_p0;

  // Sign-extend the full-width product to the accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [2*DATA_W-1:0] p);
    return ACC_W'(p);
  endfunction

  assign a_s  = $signed(a);
  assign b_s  = $signed(b);
  assign prod = (2*DATA_W)'(a_s) * (2*DATA_W)'(b_s);

  // Stage p0: accumulator register; plain two's-complement wrap, no saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0 <= '0;
    end else if (clr) begin
      acc_p0 <= '0;
    end else if (en) begin
      acc_p0 <= acc_p0 + sext_prod(prod);
    end
  end

  assign acc = acc_p0;

endmodule

// File: rtl/dotp_controller.sv
// Dot-product controller: accepts a command (two base addresses, a length
// and a destination register), reads A[i] then B[i] through a shared memory
// port with a request/grant handshake, accumulates signed A[i]*B[i], and
// presents the result on a valid/ready writeback port.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            : command handshake (ready only in IDLE)
//   cmd_a_addr, cmd_b_addr         : vector base word addresses
//   cmd_len, cmd_rd                : element count, destination register
//   mem_req/mem_addr/mem_gnt       : read request to the shared-port arbiter
//   mem_rvalid/mem_rdata           : read response
//   wb_valid/wb_ready/wb_rd/wb_data: result writeback
//   busy                           : high whenever not IDLE
module dotp_controller
  import dotp_pkg::*;
#(
  parameter int ADDR_WIDTH   = DOTP_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DOTP_DATA_WIDTH,
  parameter int LEN_WIDTH    = DOTP_LEN_WIDTH,
  parameter int RESULT_WIDTH = DOTP_RESULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_a_addr,
  input  logic [ADDR_WIDTH-1:0]   cmd_b_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [4:0]              cmd_rd,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [4:0]              wb_rd,
  output logic [RESULT_WIDTH-1:0] wb_data,
  output logic                    busy
);

  dotp_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [ADDR_WIDTH-1:0]   b_addr;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    idx;
  logic [4:0]              rd_q;
  logic [DATA_WIDTH-1:0]   op_a;
  logic [RESULT_WIDTH-1:0] acc;
  logic                    cmd_fire;
  logic                    a_fire;
  logic                    b_fire;
  logic                    last_elem;

  assign cmd_fire  = cmd_valid && cmd_ready;
  // rvalid only matters while a read is outstanding.
  assign a_fire    = (state == WAIT_A) && mem_rvalid;
  assign b_fire    = (state == WAIT_B) && mem_rvalid;
  assign last_elem = (idx == len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode from state only, so an asynchronous reset drops
  // mem_req / wb_valid / busy immediately.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          state_nxt = (cmd_len == '0) ? DONE : REQ_A;
        end
      end
      REQ_A: begin
        mem_req  = 1'b1;
        mem_addr = a_addr;
        if (mem_gnt) state_nxt = WAIT_A;
      end
      WAIT_A: begin
        if (mem_rvalid) state_nxt = REQ_B;
      end
      REQ_B: begin
        mem_req  = 1'b1;
        mem_addr = b_addr;
        if (mem_gnt) state_nxt = WAIT_B;
      end
      WAIT_B: begin
        if (mem_rvalid) state_nxt = last_elem ? DONE : REQ_A;
      end
      DONE: begin
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        wb_data  = acc;
        if (wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_addr <= '0;
      b_addr <= '0;
      len_q  <= '0;
      idx    <= '0;
      rd_q   <= '0;
      op_a   <= '0;
    end else begin
      if (cmd_fire) begin
        a_addr <= cmd_a_addr;
        b_addr <= cmd_b_addr;
        len_q  <= cmd_len;
        rd_q   <= cmd_rd;
        idx    <= '0;
      end
      if (a_fire) begin
        op_a <= mem_rdata;
      end
      if (b_fire) begin
        a_addr <= a_addr + ADDR_WIDTH'(1);
        b_addr <= b_addr + ADDR_WIDTH'(1);
        idx    <= idx + LEN_WIDTH'(1);
      end
    end
  end

  dotp_mac #(
    .DATA_W (DATA_WIDTH),
    .ACC_W  (RESULT_WIDTH)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (cmd_fire),
    .en  (b_fire),
    .a   (op_a),
    .b   (mem_rdata),
    .acc (acc)
  );

endmodule

// File: tb/tb_dotp_controller.sv
// Self-checking bench for dotp_controller: behavioural memory responder with
// selectable grant policy, and a sum-of-products reference model.
module tb_dotp_controller;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int RW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_a_addr;
  logic [AW-1:0] cmd_b_addr;
  logic [LW-1:0] cmd_len;
  logic [4:0]    cmd_rd;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_rd;
  logic [RW-1:0] wb_data;
  logic          busy;

  always #5 clk = ~clk;

  dotp_controller #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .LEN_WIDTH    (LW),
    .RESULT_WIDTH (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a_addr (cmd_a_addr),
    .cmd_b_addr (cmd_b_addr),
    .cmd_len    (cmd_len),
    .cmd_rd     (cmd_rd),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .busy       (busy)
  );

  logic [DW-1:0] mem [0:4095];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: 0 = always grant, 1 = random grant,
  // 2 = hold grant low 5 cycles on every B request.
  int            stall_mode = 0;
  int            stall_cnt  = 0;
  int            stall_cycles = 0;
  int            req_cycles = 0;
  int            grants = 0;
  int            addr_err = 0;
  logic          pending = 1'b0;
  logic [AW-1:0] pend_addr;
  logic [AW-1:0] stall_addr;
  logic [AW-1:0] addr_log[$];

  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending    = 1'b0;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        stall_cnt  = 0;
      end else begin
        mem_rvalid = pending;
        mem_rdata  = pending ? mem[pend_addr] : DW'($urandom);
        // Spurious response while a request is still pending grant.
        if (!pending && mem_req && $urandom_range(0, 1) == 1) mem_rvalid = 1'b1;
        pending = 1'b0;
        if (!mem_req && mem_addr != '0) addr_err++;
        if (mem_req) begin
          req_cycles++;
          case (stall_mode)
            0: mem_gnt = 1'b1;
            1: mem_gnt = ($urandom_range(0, 2) != 0);
            default: begin
              if (stall_cnt > 0 && mem_addr != stall_addr) addr_err++;
              if (grants % 2 == 1 && stall_cnt < 5) begin
                if (stall_cnt == 0) stall_addr = mem_addr;
                mem_gnt = 1'b0;
                stall_cnt++;
              end else begin
                mem_gnt = 1'b1;
              end
            end
          endcase
          if (mem_gnt) begin
            pending   = 1'b1;
            pend_addr = mem_addr;
            addr_log.push_back(mem_addr);
            grants++;
            stall_cnt = 0;
          end else begin
            stall_cycles++;
          end
        end else begin
          mem_gnt = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic clear_stats();
    addr_log.delete();
    stall_cycles = 0;
    req_cycles   = 0;
    addr_err     = 0;
    grants       = 0;
  endtask

  task automatic handshake(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [LW-1:0] len, input logic [4:0] rd, input string tag);
    chk({tag, " cmd_ready idle"}, cmd_ready, 1'b1);
    cmd_valid  = 1'b1;
    cmd_a_addr = a;
    cmd_b_addr = b;
    cmd_len    = len;
    cmd_rd     = rd;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_a_addr = AW'($urandom);
    cmd_b_addr = AW'($urandom);
    cmd_len    = LW'($urandom);
    cmd_rd     = 5'($urandom);
  endtask

  // Runs one command; exp_lat < 0 means only the generic latency rule is checked.
  task automatic run_cmd(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [LW-1:0] len, input logic [4:0] rd,
                         input int bp, input int exp_lat, input string tag,
                         output logic [RW-1:0] result);
    longint        exp_sum;
    logic [AW-1:0] ai, bi;
    logic [AW-1:0] exp_addr[$];
    int            cyc;
    int            bad;
    exp_sum = 0;
    for (int i = 0; i < int'(len); i++) begin
      ai = a + AW'(i);
      bi = b + AW'(i);
      exp_sum += longint'($signed(mem[ai])) * longint'($signed(mem[bi]));
      exp_addr.push_back(ai);
      exp_addr.push_back(bi);
    end
    clear_stats();
    handshake(a, b, len, rd, tag);
    cyc = 1;
    while (!wb_valid && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " wb_valid"}, wb_valid, 1'b1);
    chk({tag, " latency"}, cyc, 4 * int'(len) + 1 + stall_cycles);
    if (exp_lat >= 0) chk({tag, " latency abs"}, cyc, exp_lat);
    chk({tag, " wb_data"}, wb_data, exp_sum);
    chk({tag, " wb_rd"}, wb_rd, rd);
    chk({tag, " busy"}, busy, 1'b1);
    chk({tag, " mem_req done"}, mem_req, 1'b0);
    chk({tag, " n_reads"}, addr_log.size(), exp_addr.size());
    bad = 0;
    for (int i = 0; i < addr_log.size() && i < exp_addr.size(); i++)
      if (addr_log[i] != exp_addr[i]) bad++;
    chk({tag, " read addrs"}, bad, 0);
    chk({tag, " addr idle/stable"}, addr_err, 0);
    result = wb_data;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      chk({tag, " bp wb_valid"}, wb_valid, 1'b1);
      chk({tag, " bp wb_data"}, wb_data, exp_sum);
      chk({tag, " bp cmd_ready"}, cmd_ready, 1'b0);
    end
    // Offer a command during the accept cycle; it must not be taken.
    wb_ready   = 1'b1;
    cmd_valid  = 1'b1;
    cmd_len    = 8'd1;
    #1;
    chk({tag, " cmd_ready on wb"}, cmd_ready, 1'b0);
    @(posedge clk); #1;
    wb_ready  = 1'b0;
    cmd_valid = 1'b0;
    chk({tag, " wb_valid after"}, wb_valid, 1'b0);
    chk({tag, " busy after"}, busy, 1'b0);
    chk({tag, " cmd_ready after"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] res;
    logic [AW-1:0] ra, rb;
    logic [LW-1:0] rl;
    int            wcnt;

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_a_addr = '0; cmd_b_addr = '0;
    cmd_len = '0; cmd_rd = '0; wb_ready = 1'b0;

    @(posedge clk); #1;
    chk("rst cmd_ready", cmd_ready, 1'b0);
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst wb_valid", wb_valid, 1'b0);
    chk("rst wb_data", wb_data, 0);
    chk("rst wb_rd", wb_rd, 0);
    chk("rst busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    chk("post-rst cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;

    // Basic vector
    for (int i = 0; i < 4; i++) begin
      mem[12'h010 + i] = DW'(i + 1);
      mem[12'h020 + i] = DW'(i + 5);
    end
    run_cmd(12'h010, 12'h020, 8'd4, 5'd7, 0, 17, "basic", res);
    chk("basic const", res, 64'd70);

    // Signed extremes
    mem[12'h100] = 32'hFFFF_FFFD; mem[12'h101] = 32'h7FFF_FFFF;
    mem[12'h200] = 32'd4;         mem[12'h201] = 32'h7FFF_FFFF;
    run_cmd(12'h100, 12'h200, 8'd2, 5'd3, 0, 9, "signed", res);
    chk("signed const", res, 64'h3FFF_FFFE_FFFF_FFF5);

    // Zero length
    run_cmd(12'h100, 12'h200, 8'd0, 5'd9, 0, 1, "zero", res);
    chk("zero const", res, 64'd0);
    chk("zero no mem_req", req_cycles, 0);

    // Arbitration stall on every B request
    stall_mode = 2;
    run_cmd(12'h010, 12'h020, 8'd2, 5'd1, 0, 19, "stall", res);
    chk("stall const", res, 64'd17);
    chk("stall cycles", stall_cycles, 10);
    stall_mode = 0;

    // Address wrap with writeback backpressure
    mem[12'hFFF] = 32'd10; mem[12'h000] = 32'hFFFF_FFFE;
    mem[12'h300] = 32'd3;  mem[12'h301] = 32'd7;
    run_cmd(12'hFFF, 12'h300, 8'd2, 5'd31, 3, 9, "wrap", res);
    chk("wrap const", res, 64'd16);
    chk("wrap 2nd A addr", addr_log[2], 12'h000);

    // Reset during WAIT_B of element 2
    for (int i = 0; i < 3; i++) begin
      mem[12'h400 + i] = DW'(i + 1);
      mem[12'h500 + i] = DW'(i + 4);
    end
    clear_stats();
    handshake(12'h400, 12'h500, 8'd3, 5'd5, "midrst");
    wcnt = 0;
    while (grants < 4 && wcnt < 100) begin
      @(posedge clk); #1;
      wcnt++;
    end
    chk("midrst reached WAIT_B", grants, 4);
    rst = 1'b1;
    #1;
    chk("midrst mem_req", mem_req, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst wb_valid", wb_valid, 1'b0);
    chk("midrst cmd_ready", cmd_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst wb_data", wb_data, 0);
    chk("midrst cmd_ready rel", cmd_ready, 1'b1);
    mem[12'h600] = 32'd2; mem[12'h601] = 32'd3;
    run_cmd(12'h600, 12'h601, 8'd1, 5'd2, 0, 5, "after-rst", res);
    chk("after-rst const", res, 64'd6);

    // Randomized commands with random grant and backpressure
    stall_mode = 1;
    for (int t = 0; t < 10; t++) begin
      ra = AW'($urandom);
      rb = AW'($urandom);
      rl = LW'($urandom_range(0, 12));
      for (int i = 0; i < int'(rl); i++) begin
        mem[ra + AW'(i)] = DW'($urandom);
        mem[rb + AW'(i)] = DW'($urandom);
      end
      run_cmd(ra, rb, rl, 5'($urandom), $urandom_range(0, 2), -1, $sformatf("rand%0d", t), res);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
